mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//   Memory stage directly downstream of the execute stage. Consumes ALU_result (address) and the forwarded Rm value (store data).
//   Performs 32-bit loads/stores over a 16-bit external SRAM (two half-word accesses, fixed wait states).
//   Holds mem_ready low to freeze the pipeline while an access is in flight, and registers the MEM/WB payload.
// PARAMETERS
//   DATA_BASE    32'd1024  byte address mapped to SRAM word 0; sram word addr = (alu_result-DATA_BASE)>>1
//   SRAM_AW      18        SRAM half-word address width
//   WAIT_CYCLES  2         cycles each half-word access is held on the SRAM bus (>=1)
// PORTS
//   clk           in   1   clock, all state on posedge
//   rst           in   1   synchronous, active-low reset
//   wb_en_in      in   1   write-back enable from EXE/MEM
//   mem_read      in   1   load request
//   mem_write     in   1   store request
//   dest_in       in   4   destination register index
//   alu_result    in   32  byte address / non-memory result
//   st_val        in   32  store data (Rm after forwarding)
//   mem_ready     out  1   0 = access in flight, upstream stages must freeze
//   wb_en_out     out  1   registered write-back enable
//   mem_r_en_out  out  1   registered load flag (selects mem_result in WB)
//   alu_out       out  32  registered alu_result
//   mem_result    out  32  registered load data
//   dest_out      out  4   registered destination
//   sram_addr     out  SRAM_AW  half-word address
//   sram_wdata    out  16  write half-word
//   sram_rdata    in   16  read half-word, valid at end of each access window
//   sram_we_n     out  1   active-low write strobe
//   sram_oe_n     out  1   active-low output enable
// BEHAVIOUR
//   - Reset (rst==0 at posedge): FSM->IDLE, counter=0, all registered outputs 0, sram_we_n=sram_oe_n=1, sram_addr=0, sram_wdata=0.
//   - FSM states: IDLE, LO, HI, DONE.
//   - IDLE, no request: mem_ready=1. Payload registers load from the inputs every cycle; mem_result holds its value.
//   - IDLE, request (mem_read|mem_write): mem_ready=0 combinationally. Next state LO, cnt=0, latch addr/data/op.
//   - LO: drive sram_addr = base half-word addr (bit0=0), sram_wdata = st_val[15:0].
//     Assert we_n=0 (store) or oe_n=0 (load) for WAIT_CYCLES cycles.
//     On the last cycle, capture rdata into lo half; then go HI with cnt=0.
//   - HI: same as LO for addr|1 and st_val[31:16], capturing the hi half. Then go DONE.
//   - DONE: all strobes inactive, mem_ready=1. The payload registers load, and mem_result = {hi,lo} for loads
//     (unchanged for stores). Next state is IDLE.
//   - Stall length: mem_ready low for 1+2*WAIT_CYCLES cycles (5 at default); payload visible the cycle after DONE.
//   - Upstream holds all inputs stable while mem_ready==0; the block uses its latched copies regardless.
//   - mem_read & mem_write together: treated as a store; mem_r_en_out=0.
//   - Address arithmetic is modulo 2^32, then truncated to SRAM_AW; below-base addresses wrap, no fault.
//   - The counter saturates at WAIT_CYCLES-1; an IDLE request never starts an access while in LO/HI/DONE.
//   - Reset mid-access: abort at that edge, strobes deasserted in the next cycle, no partial payload emitted.
// CONFIGURATION
//   MEM_STAGE_READ_BUF_EN defined: one-entry buffer {valid, word addr, data} of the last completed load.
//     Load hit in IDLE: no SRAM access and mem_ready stays 1; payload and mem_result load from the buffer next edge.
//     Store to the buffered address updates the buffer data at DONE. Reset clears valid.
//   Undefined: every load takes the full SRAM sequence; no buffer state exists.
// STRUCTURE
//   mem_stage_pkg: state enum (IDLE/LO/HI/DONE), SRAM strobe idle constants, half-word select constants.
//   Sub-module sram_word_ctrl: FSM + wait counter + SRAM pins.
//   The mem_stage top holds the payload registers, address translation and the optional read buffer.
// TESTING
//   1 Non-memory op alu_result=32'h55, wb_en=1, dest=3 -> mem_ready stays 1; alu_out=32'h55, dest_out=3 next cycle.
//   2 Store 32'hDEADBEEF at 1024 then load 1024 -> SRAM[0]=16'hBEEF, SRAM[1]=16'hDEAD.
//     Each op has 5 ready-low cycles; mem_result=32'hDEADBEEF.
//   3 Strobe timing at default: we_n low exactly 2 cycles per half; addr 0 then 1; oe_n never low during store.
//   4 rst=0 in 2nd LO cycle of a load -> next cycle strobes inactive, mem_ready=1, all outputs 0.
//   5 mem_read=mem_write=1, addr 1028 -> store occurs at half-words 2,3 and mem_r_en_out=0.
//   6 READ_BUF_EN: repeat load of 1024 -> zero stall, correct data; store 32'h1 to 1024 then load -> 32'h1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, SRAM strobe idle level, half-word selects.
// No logic or latency of its own; imported by mem_stage and sram_word_ctrl.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic STROBE_OFF = 1'b1;
    localparam logic HALF_LO    = 1'b0;
    localparam logic HALF_HI    = 1'b1;

endpackage

// File: rtl/sram_word_ctrl.sv
// 32-bit word access as two half-word SRAM cycles, each held WAIT_CYCLES; busy from start until DONE.
// Latches address/data/op at start; start is ignored outside IDLE.
module sram_word_ctrl
    import mem_stage_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_write,
    input  logic [SRAM_AW-1:0] base_addr,
    input  logic [31:0]        wdata,
    output logic               idle,
    output logic               done,
    output logic [31:0]        rd_word,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [SRAM_AW-1:0] base_q;
    logic [15:0]        st_hi_q;
    logic [15:0]        lo_q;
    logic [15:0]        hi_q;
    logic               last;

    assign last    = (cnt == CNT_LAST);
    assign idle    = (state == IDLE);
    assign done    = (state == DONE);
    assign rd_word = {hi_q, lo_q};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            base_q     <= '0;
            st_hi_q    <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            sram_we_n  <= STROBE_OFF;
            sram_oe_n  <= STROBE_OFF;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LO;
                        cnt        <= '0;
                        base_q     <= base_addr;
                        st_hi_q    <= wdata[31:16];
                        sram_addr  <= base_addr;
                        sram_wdata <= wdata[15:0];
                        sram_we_n  <= ~is_write;
                        sram_oe_n  <= is_write;
                    end
                end
                LO: begin
                    // Strobe stays asserted across the half boundary; only address and data move.
                    if (last) begin
                        lo_q       <= sram_rdata;
                        state      <= HI;
                        cnt        <= '0;
                        sram_addr  <= base_q | {{(SRAM_AW-1){1'b0}}, HALF_HI};
                        sram_wdata <= st_hi_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HI: begin
                    if (last) begin
                        hi_q      <= sram_rdata;
                        state     <= DONE;
                        cnt       <= '0;
                        sram_we_n <= STROBE_OFF;
                        sram_oe_n <= STROBE_OFF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: MEM/WB payload registers, SRAM address translation, 1+2*WAIT_CYCLES stall per access via mem_ready.
// MEM_STAGE_READ_BUF_EN adds a one-word buffer of the last load; hits complete with no stall.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] DATA_BASE   = 32'd1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [3:0]         dest_in,
    input  logic [31:0]        alu_result,
    input  logic [31:0]        st_val,
    output logic               mem_ready,
    output logic               wb_en_out,
    output logic               mem_r_en_out,
    output logic [31:0]        alu_out,
    output logic [31:0]        mem_result,
    output logic [3:0]         dest_out,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_wdata,
    input  logic [15:0]        sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    logic [31:0]        byte_off;
    logic [SRAM_AW-1:0] base_word;
    logic               unused_off_bits;
    logic               req;
    logic               is_load;
    logic               hit;
    logic [31:0]        hit_data;
    logic               start;
    logic               idle;
    logic               done;
    logic [31:0]        rd_word;

    logic               wb_q;
    logic               rd_q;
    logic [3:0]         dest_q;
    logic [31:0]        alu_q;

    // Modulo-2^32 offset; below-base addresses simply wrap into the SRAM window.
    assign byte_off        = alu_result - DATA_BASE;
    assign base_word       = {byte_off[SRAM_AW:2], HALF_LO};
    assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

    assign req     = mem_read | mem_write;
    assign is_load = mem_read & ~mem_write;

`ifdef MEM_STAGE_READ_BUF_EN
    logic               buf_vld;
    logic [SRAM_AW-1:0] buf_addr;
    logic [31:0]        buf_data;
    logic [SRAM_AW-1:0] acc_addr;
    logic [31:0]        acc_st;

    assign hit      = is_load & buf_vld & (buf_addr == base_word);
    assign hit_data = buf_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            buf_vld  <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
            acc_addr <= '0;
            acc_st   <= '0;
        end else begin
            if (start) begin
                acc_addr <= base_word;
                acc_st   <= st_val;
            end
            if (done) begin
                if (rd_q) begin
                    buf_vld  <= 1'b1;
                    buf_addr <= acc_addr;
                    buf_data <= rd_word;
                end else if (buf_vld && (buf_addr == acc_addr)) begin
                    buf_data <= acc_st;
                end
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    assign start     = idle & req & ~hit;
    assign mem_ready = idle ? ~start : done;

    sram_word_ctrl #(
        .SRAM_AW     (SRAM_AW),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .is_write   (mem_write),
        .base_addr  (base_word),
        .wdata      (st_val),
        .idle       (idle),
        .done       (done),
        .rd_word    (rd_word),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_q         <= 1'b0;
            rd_q         <= 1'b0;
            dest_q       <= '0;
            alu_q        <= '0;
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_out      <= '0;
            mem_result   <= '0;
            dest_out     <= '0;
        end else if (idle) begin
            if (start) begin
                wb_q   <= wb_en_in;
                rd_q   <= is_load;
                dest_q <= dest_in;
                alu_q  <= alu_result;
            end else begin
                wb_en_out    <= wb_en_in;
                mem_r_en_out <= is_load;
                alu_out      <= alu_result;
                dest_out     <= dest_in;
                if (hit) begin
                    mem_result <= hit_data;
                end
            end
        end else if (done) begin
            wb_en_out    <= wb_q;
            mem_r_en_out <= rd_q;
            alu_out      <= alu_q;
            dest_out     <= dest_q;
            if (rd_q) begin
                mem_result <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed ops, queued expected payloads checked by a monitor on each accepted op.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_read, mem_write;
    logic [3:0]  dest_in;
    logic [31:0] alu_result, st_val;
    logic        mem_ready, wb_en_out, mem_r_en_out;
    logic [31:0] alu_out, mem_result;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_we_n, sram_oe_n;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .wb_en_in     (wb_en_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .dest_in      (dest_in),
        .alu_result   (alu_result),
        .st_val       (st_val),
        .mem_ready    (mem_ready),
        .wb_en_out    (wb_en_out),
        .mem_r_en_out (mem_r_en_out),
        .alu_out      (alu_out),
        .mem_result   (mem_result),
        .dest_out     (dest_out),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_we_n    (sram_we_n),
        .sram_oe_n    (sram_oe_n)
    );

    logic [15:0] sram_mem [0:15];
    initial for (int i = 0; i < 16; i++) sram_mem[i] = 16'h0;
    assign sram_rdata = !sram_oe_n ? sram_mem[sram_addr[3:0]] : 16'h0;
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[3:0]] <= sram_wdata;

    typedef struct {
        logic        wb;
        logic        rd;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic drv_vld = 1'b0;
    logic fire_q = 1'b0;
    int   we0 = 0, we1 = 0, oe_cnt = 0;

`ifdef MEM_STAGE_READ_BUF_EN
    localparam int HIT_STALL = 0;
`else
    localparam int HIT_STALL = 5;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (fire_q) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty actual=output required=none");
            end else begin
                e = sb.pop_front();
                chk("wb_en_out", {31'b0, wb_en_out}, {31'b0, e.wb});
                chk("mem_r_en_out", {31'b0, mem_r_en_out}, {31'b0, e.rd});
                chk("dest_out", {28'b0, dest_out}, {28'b0, e.dest});
                chk("alu_out", alu_out, e.alu);
                chk("mem_result", mem_result, e.res);
            end
        end
        fire_q = drv_vld && mem_ready && rst;
        if (!sram_we_n) begin
            if (sram_addr == 18'd0) we0++;
            else if (sram_addr == 18'd1) we1++;
        end
        if (!sram_oe_n) oe_cnt++;
    end

    task automatic bubble();
        drv_vld = 1'b0;
        wb_en_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        dest_in = 4'd0; alu_result = 32'd0; st_val = 32'd0;
    endtask

    task automatic issue(input logic wb, input logic rd, input logic wr, input logic [3:0] d,
                         input logic [31:0] a, input logic [31:0] s, input logic [31:0] exp_res,
                         input int exp_stall, input string nm);
        exp_t e;
        int   stall = 0;
        bit   ok = 0;
        e.wb = wb; e.rd = rd & ~wr; e.dest = d; e.alu = a; e.res = exp_res;
        sb.push_back(e);
        wb_en_in = wb; mem_read = rd; mem_write = wr;
        dest_in = d; alu_result = a; st_val = s; drv_vld = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) begin ok = 1; break; end
            stall++;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=ready", nm, stall);
            void'(sb.pop_back());
            bubble();
        end else begin
            @(posedge clk);
            #1;
            bubble();
            chk({nm, "_stall"}, stall, exp_stall);
        end
    endtask

    initial begin
        rst = 1'b0;
        bubble();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wb_en_out", {31'b0, wb_en_out}, 32'd0);
        chk("rst_alu_out", alu_out, 32'd0);
        chk("rst_mem_result", mem_result, 32'd0);
        chk("rst_sram_addr", {14'b0, sram_addr}, 32'd0);
        chk("rst_strobes", {30'b0, sram_we_n, sram_oe_n}, 32'd3);
        chk("rst_ready", {31'b0, mem_ready}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;

        issue(1'b1, 1'b0, 1'b0, 4'd3, 32'h55, 32'h0, 32'h0, 0, "nonmem");

        we0 = 0; we1 = 0; oe_cnt = 0;
        issue(1'b0, 1'b0, 1'b1, 4'd0, 32'd1024, 32'hDEADBEEF, 32'h0, 5, "store1024");
        chk("store_we_addr0", we0, 32'd2);
        chk("store_we_addr1", we1, 32'd2);
        chk("store_oe_never", oe_cnt, 32'd0);
        chk("sram0", {16'b0, sram_mem[0]}, 32'h0000BEEF);
        chk("sram1", {16'b0, sram_mem[1]}, 32'h0000DEAD);

        oe_cnt = 0;
        issue(1'b1, 1'b1, 1'b0, 4'd5, 32'd1024, 32'h0, 32'hDEADBEEF, 5, "load1024");
        chk("load_oe_cycles", oe_cnt, 32'd4);

        issue(1'b1, 1'b1, 1'b0, 4'd6, 32'd1024, 32'h0, 32'hDEADBEEF, HIT_STALL, "reload1024");
        issue(1'b0, 1'b0, 1'b1, 4'd0, 32'd1024, 32'h1, 32'hDEADBEEF, 5, "store1");
        issue(1'b1, 1'b1, 1'b0, 4'd7, 32'd1024, 32'h0, 32'h1, HIT_STALL, "load_after_store");

        issue(1'b1, 1'b1, 1'b1, 4'd8, 32'd1028, 32'hCAFE1234, 32'h1, 5, "rdwr1028");
        chk("sram2", {16'b0, sram_mem[2]}, 32'h00001234);
        chk("sram3", {16'b0, sram_mem[3]}, 32'h0000CAFE);

        issue(1'b0, 1'b0, 1'b1, 4'd0, 32'd1020, 32'hA5A55A5A, 32'h1, 5, "store_wrap");
        chk("sram14", {16'b0, sram_mem[14]}, 32'h00005A5A);
        chk("sram15", {16'b0, sram_mem[15]}, 32'h0000A5A5);
        issue(1'b1, 1'b1, 1'b0, 4'd9, 32'd1020, 32'h0, 32'hA5A55A5A, 5, "load_wrap");

        wb_en_in = 1'b1; mem_read = 1'b1; mem_write = 1'b0;
        dest_in = 4'd4; alu_result = 32'd1024; st_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_oe_active", {31'b0, sram_oe_n}, 32'd0);
        rst = 1'b0;
        bubble();
        @(posedge clk);
        #1;
        chk("abort_strobes", {30'b0, sram_we_n, sram_oe_n}, 32'd3);
        chk("abort_ready", {31'b0, mem_ready}, 32'd1);
        chk("abort_mem_result", mem_result, 32'd0);
        chk("abort_payload", {alu_out[27:0], dest_out}, 32'd0);
        chk("abort_flags", {30'b0, wb_en_out, mem_r_en_out}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(1'b1, 1'b1, 1'b0, 4'd2, 32'd1028, 32'h0, 32'hCAFE1234, 5, "load_post_rst");

        repeat (3) @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
